// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int unsigned INSTR_W      = 32;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [INSTR_W-1:0]    instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DROP  = 2'd1,
        S_ERR   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush beats push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset; entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_addr_unit.sv
// Instruction-fetch front end: PC register, imem req/ack handshake, output FIFO.
// Optional perf counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_addr_unit
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC   = ADDR_W'(DEF_RESET_PC),
    parameter int unsigned        FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                imem_req,
    output logic [ADDR_W-3:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    input  logic                instr_ready,
    output logic                misaligned,
    output logic [31:0]         perf_fetched,
    output logic [15:0]         perf_dropped
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WA_W  = ADDR_W - 2;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [WA_W-1:0]   drop_addr_q, drop_addr_d;
    logic              mis_q, mis_d;
    logic              push, pop, flush, drop_ev;
    logic              ack_v, aligned;
    logic [CNT_W-1:0]  fifo_count;
    fetch_entry_t      head;

    // Request is withheld while reset is asserted so a stray ack is never taken.
    assign imem_req = !reset && ((state_q == S_DROP) ||
                      ((state_q == S_FETCH) && (fifo_count < CNT_W'(FIFO_DEPTH))));
    assign imem_addr   = (state_q == S_DROP) ? drop_addr_q : pc_q[ADDR_W-1:2];
    assign ack_v       = imem_ack && imem_req;
    assign aligned     = (redirect_pc[1:0] == 2'b00);
    assign instr_valid = (fifo_count != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr       = head.instr;
    assign instr_pc    = ADDR_W'(head.pc);
    assign misaligned  = mis_q;

    // Next-state, PC and FIFO control.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        mis_d       = mis_q;
        push        = 1'b0;
        flush       = 1'b0;
        drop_ev     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    flush = 1'b1;
                    if (aligned) pc_d = redirect_pc;
                    else         mis_d = 1'b1;
                    if (imem_req && !imem_ack) begin
                        state_d     = S_DROP;
                        drop_addr_d = pc_q[ADDR_W-1:2];
                    end else begin
                        state_d = aligned ? S_FETCH : S_ERR;
                        drop_ev = ack_v;
                    end
                end else if (ack_v) begin
                    push = 1'b1;
                    pc_d = pc_q + ADDR_W'(4);
                end
            end
            S_DROP: begin
                if (redirect) begin
                    flush = 1'b1;
                    if (aligned) pc_d = redirect_pc;
                    else         mis_d = 1'b1;
                end
                if (ack_v) begin
                    drop_ev = 1'b1;
                    state_d = mis_d ? S_ERR : S_FETCH;
                end
            end
            S_ERR: begin
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            mis_q       <= mis_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ('{pc: DEF_ADDR_W'(pc_q), instr: imem_rdata}),
        .pop       (pop),
        .flush     (flush),
        .count     (fifo_count),
        .head      (head)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [15:0] dropped_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            dropped_q <= '0;
        end else begin
            if (push && (fetched_q != '1))    fetched_q <= fetched_q + 32'd1;
            if (drop_ev && (dropped_q != '1)) dropped_q <= dropped_q + 16'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_dropped = dropped_q;
`else
    logic unused_perf;
    assign unused_perf  = drop_ev;
    assign perf_fetched = '0;
    assign perf_dropped = '0;
`endif

endmodule
